// File: rtl/dlx_pkg.sv
// Shared DLX datapath constants and the writeback queue entry type.
package dlx_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One buffered load result; live=0 means a younger ALU write superseded it.
  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // One-hot decode of a register address.
  function automatic logic [NUM_REGS-1:0] rd_decode(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] d;
    d     = '0;
    d[rd] = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// In-order load-result queue with per-entry squash and pending-register mask.
module wb_queue
  import dlx_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  squash,
  input  logic [REG_ADDR_W-1:0] squash_rd,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic [NUM_REGS-1:0]   pending
);

  wb_entry_t          ent [DEPTH];
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [DEPTH-1:0]   hit;
  logic               push_ok;
  logic               pop_ok;
  logic               push_live;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = ent[head_ptr];

  // The squashing ALU write is younger than a same-cycle push, so the push lands dead.
  assign push_live = !(squash && (squash_rd == push_rd));

  // Per-entry squash compare against the ALU destination.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign hit[i] = squash && (ent[i].rd == squash_rd);
  end

  // Entry storage, pointers and occupancy. Popped entries drop their live
  // bit so the pending mask only ever sees occupied slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (hit[i]) ent[i].live <= 1'b0;
      if (pop_ok) begin
        ent[head_ptr].live <= 1'b0;
        head_ptr           <= head_ptr + 1'b1;
      end
      if (push_ok) begin
        ent[tail_ptr].live <= push_live;
        ent[tail_ptr].rd   <= push_rd;
        ent[tail_ptr].data <= push_data;
        tail_ptr           <= tail_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pending mask: OR of the destination decodes of all live entries.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent[i].live) pending = pending | rd_decode(ent[i].rd);
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take the register-file port immediately,
// load results are queued in order and drained when the ALU is idle.
module wb_arbiter
  import dlx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rd,
  input  logic [31:0]             alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [4:0]              mem_rd,
  input  logic [31:0]             mem_data,
  output logic                    reg_write,
  output logic [4:0]              write_reg,
  output logic [31:0]             write_data,
  output logic [31:0]             pending,
  output logic [$clog2(DEPTH):0]  q_count
);

  wb_entry_t head;
  logic      full;
  logic      empty;
  logic      alu_wr;
  logic      push;
  logic      pop;

  // r0 is hardwired zero: writes to it are dropped, loads to it complete but vanish.
  assign alu_wr    = alu_valid && (alu_rd != '0);
  assign mem_ready = reset && !full;
  assign push      = mem_valid && mem_ready && (mem_rd != '0);
  assign pop       = !alu_wr && !empty;

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (mem_rd),
    .push_data (mem_data),
    .pop       (pop),
    .squash    (alu_wr),
    .squash_rd (alu_rd),
    .head      (head),
    .count     (q_count),
    .full      (full),
    .empty     (empty),
    .pending   (pending)
  );

  // Output register: ALU has priority; a squashed head pops without writing
  // and address/data hold so the port does not toggle needlessly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (alu_wr) begin
      reg_write  <= 1'b1;
      write_reg  <= alu_rd;
      write_data <= alu_data;
    end else if (pop) begin
      reg_write <= head.live;
      if (head.live) begin
        write_reg  <= head.rd;
        write_data <= head.data;
      end
    end else begin
      reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, multi-cycle sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending;
  logic [2:0]  q_count;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .pending(pending), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of pending loads plus the expected output port.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ment_t;

  ment_t       mq[$];
  logic        m_rw = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_wd = '0;
  logic [36:0] wlog[$];

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) if (mq[i].live) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  // One clock: check the handshake, advance the model, clock the DUT, compare.
  task automatic tick();
    bit    aw, xfer;
    ment_t h, e;
    chk("mem_ready", mem_ready, (mq.size() < DEPTH));
    aw   = alu_valid && (alu_rd != 0);
    xfer = mem_valid && (mq.size() < DEPTH);
    if (aw) foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 0;
    if (aw) begin
      m_rw = 1; m_wr = alu_rd; m_wd = alu_data;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_rw = h.live;
      if (h.live) begin m_wr = h.rd; m_wd = h.data; end
    end else begin
      m_rw = 0;
    end
    if (xfer && mem_rd != 0) begin
      e.rd = mem_rd; e.data = mem_data; e.live = !(aw && mem_rd == alu_rd);
      mq.push_back(e);
    end
    @(posedge clk); #1;
    chk("reg_write", reg_write, m_rw);
    chk("write_reg", write_reg, m_wr);
    chk("write_data", write_data, m_wd);
    chk("q_count", q_count, mq.size());
    chk("pending", pending, model_pending());
    if (reg_write) wlog.push_back({write_reg, write_data});
  endtask

  typedef struct {
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic mv; logic [4:0] mr; logic [31:0] md;
    logic rw; logic [4:0] wr; logic [31:0] wd;
    logic [2:0] cnt; logic [31:0] pend;
  } vec_t;

  vec_t vt[15];

  initial begin
    bit          x;
    int          sent, acc;
    logic [36:0] w;

    // Directed vectors from a clean reset; expectations worked by hand.
    vt[0]  = '{1, 5, 32'h1234, 0, 0, 0,          1, 5, 32'h1234, 0, 32'h0};
    vt[1]  = '{1, 3, 32'h33,   1, 7, 32'hAAAA,   1, 3, 32'h33,   1, 32'h80};
    vt[2]  = '{1, 3, 32'h34,   1, 8, 32'hBBBB,   1, 3, 32'h34,   2, 32'h180};
    vt[3]  = '{1, 3, 32'h35,   0, 0, 0,          1, 3, 32'h35,   2, 32'h180};
    vt[4]  = '{0, 0, 0,        0, 0, 0,          1, 7, 32'hAAAA, 1, 32'h100};
    vt[5]  = '{0, 0, 0,        0, 0, 0,          1, 8, 32'hBBBB, 0, 32'h0};
    vt[6]  = '{0, 0, 0,        0, 0, 0,          0, 8, 32'hBBBB, 0, 32'h0};
    vt[7]  = '{0, 0, 0,        1, 9, 32'h1111,   0, 8, 32'hBBBB, 1, 32'h200};
    vt[8]  = '{1, 9, 32'h2222, 0, 0, 0,          1, 9, 32'h2222, 1, 32'h0};
    vt[9]  = '{0, 0, 0,        0, 0, 0,          0, 9, 32'h2222, 0, 32'h0};
    vt[10] = '{1, 9, 32'h3333, 1, 9, 32'h4444,   1, 9, 32'h3333, 1, 32'h0};
    vt[11] = '{0, 0, 0,        0, 0, 0,          0, 9, 32'h3333, 0, 32'h0};
    vt[12] = '{1, 0, 32'hDEAD, 1, 0, 32'hBEEF,   0, 9, 32'h3333, 0, 32'h0};
    vt[13] = '{1, 0, 32'hDEAD, 1, 6, 32'h66,     0, 9, 32'h3333, 1, 32'h40};
    vt[14] = '{0, 0, 0,        0, 0, 0,          1, 6, 32'h66,   0, 32'h0};

    // Reset state while held low.
    #12;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_pending", pending, 0);
    chk("rst_mem_ready", mem_ready, 0);
    #1 reset = 1'b1;
    #1 chk("rel_mem_ready", mem_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      alu_valid = vt[i].av; alu_rd = vt[i].ar; alu_data = vt[i].ad;
      mem_valid = vt[i].mv; mem_rd = vt[i].mr; mem_data = vt[i].md;
      if (vt[i].mv) chk($sformatf("v%0d_ready", i), mem_ready, 1);
      tick();
      chk($sformatf("v%0d_rw", i), reg_write, vt[i].rw);
      chk($sformatf("v%0d_wr", i), write_reg, vt[i].wr);
      chk($sformatf("v%0d_wd", i), write_data, vt[i].wd);
      chk($sformatf("v%0d_cnt", i), q_count, vt[i].cnt);
      chk($sformatf("v%0d_pend", i), pending, vt[i].pend);
    end
    alu_valid = 0; mem_valid = 0;

    // Full queue: six ALU cycles with five loads offered, then drain.
    wlog.delete();
    sent = 0; acc = -1;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_rd = 2; alu_data = c;
      mem_valid = (sent < 5); mem_rd = 5'(10 + sent); mem_data = 32'h5000 + sent;
      x = mem_valid && mem_ready;
      tick();
      if (x) sent++;
    end
    chk("full_sent4", sent, 4);
    chk("full_ready_low", mem_ready, 0);
    alu_valid = 0;
    for (int c = 0; c < 12; c++) begin
      mem_valid = (sent < 5); mem_rd = 5'(10 + sent); mem_data = 32'h5000 + sent;
      x = mem_valid && mem_ready;
      if (x) acc = q_count;
      tick();
      if (x) sent++;
    end
    mem_valid = 0;
    chk("full_sent5", sent, 5);
    chk("full_5th_cnt", acc, 3);
    chk("full_wlog_len", wlog.size(), 11);
    for (int k = 0; k < 5; k++) begin
      w = (wlog.size() > 6 + k) ? wlog[6 + k] : '0;
      chk($sformatf("full_order%0d", k), w, {5'(10 + k), 32'h5000 + k});
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_rd    = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      tick();
    end

    // Asynchronous reset with three live loads queued.
    alu_valid = 0; mem_valid = 0;
    for (int c = 0; c < 6; c++) tick();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_rd = 1; alu_data = c;
      mem_valid = 1; mem_rd = 5'(10 + c); mem_data = 32'h7000 + c;
      tick();
    end
    alu_valid = 0; mem_valid = 0;
    chk("pre_rst_cnt", q_count, 3);
    chk("pre_rst_pend", pending, 32'h1C00);
    #3 reset = 1'b0;
    #1;
    chk("arst_reg_write", reg_write, 0);
    chk("arst_write_reg", write_reg, 0);
    chk("arst_write_data", write_data, 0);
    chk("arst_q_count", q_count, 0);
    chk("arst_pending", pending, 0);
    chk("arst_mem_ready", mem_ready, 0);
    mq.delete(); m_rw = 0; m_wr = '0; m_wd = '0;
    @(posedge clk); #2 reset = 1'b1;
    #1 chk("arst_rel_ready", mem_ready, 1);
    for (int c = 0; c < 3; c++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the pipelined DLX core. It sits between the execute/memory stages and the register file's single write port, and drives that port's reg_write, write_reg and write_data. Single-cycle ALU results are written immediately with priority. Load results arrive over a valid/ready handshake and are buffered in a small in-order queue. A pending-write mask lets decode stall on registers whose loads are still queued.

## Interface
- DEPTH, 4, load-result queue entries (power of 2, ≥2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  queue can accept; transfer when mem_valid && mem_ready
- mem_rd  in  5  load destination register
- mem_data  in  32  load data
- reg_write  out  1  register-file write enable (registered)
- write_reg  out  5  register-file write address (registered)
- write_data  out  32  register-file write data (registered)
- pending  out  32  bit i = live (unsquashed) queued entry targets register i
- q_count  out  log2(DEPTH)+1  number of queue entries, including squashed ones

## Operation
- r0 is hardwired zero:
  - alu_valid with alu_rd==0 is ignored.
  - A mem transfer with mem_rd==0 completes but is discarded; it is not pushed.
- Push: on a mem transfer with mem_rd!=0, the entry {rd, data, live=1} is appended at the tail.
- mem_ready = (q_count < DEPTH) && reset high. It is not raised by a same-cycle pop.
- Squash: an ALU write is younger than every queued entry, including an entry pushed in the same cycle.
  - On alu_valid && alu_rd!=0, every queue entry with rd==alu_rd gets live=0.
  - A same-cycle push with mem_rd==alu_rd enters the queue with live=0.
- Output selection, evaluated each cycle, registered at the edge:
  - If alu_valid && alu_rd!=0: reg_write=1, write_reg=alu_rd, write_data=alu_data. The queue does not pop.
  - Else if the queue is non-empty: pop the head.
    - Head live: reg_write=1 with the head's rd and data.
    - Head squashed: reg_write=0; write_reg and write_data hold their previous values.
  - Else: reg_write=0; write_reg and write_data hold.
- Push and pop may occur in the same cycle; q_count is then unchanged.
- Queue order is strict FIFO. Head and tail pointers wrap modulo DEPTH.
- pending is the combinational OR of the rd decodes of live entries. It reflects the state after the last clock edge.
- The queue can starve under continuous ALU traffic. This is by design: pipeline stall logic uses q_count and pending to throttle issue.

## Timing
- Write latency is 1 cycle: inputs sampled at edge N appear on reg_write, write_reg and write_data after edge N. The register file commits them at edge N+1.
- A load pushed at edge N is written out no earlier than after edge N+1 (queue, then output register).
- pending[i] rises the cycle after the push and falls the cycle after the pop or squash.
- Reset (reset low, asynchronous): reg_write=0, write_reg=0, write_data=0, queue empty, q_count=0, pending=0, mem_ready=0.
  - Reset asserted mid-operation discards all queued entries with no writes issued.
  - mem_ready=1 from the first cycle reset is high.

## Structure
- dlx_pkg holds DATA_W=32, REG_ADDR_W=5 and NUM_REGS=32, shared with regfile and the pipeline stages.
- Sub-module wb_queue contains:
  - DEPTH entries of {live, rd, data}
  - head/tail pointers and count
  - a per-entry squash compare port
  - the pending mask generation
- wb_arbiter instantiates wb_queue and contains the select logic and the output registers.

## Test plan
- Reset: with 3 live entries queued, pull reset low.
  - Immediately: reg_write=0, write_reg=0, write_data=0, q_count=0, pending=0, mem_ready=0.
  - After release: mem_ready=1.
- ALU path: alu_valid, rd=5, data=0x00001234 → the next cycle has reg_write=1, write_reg=5, write_data=0x00001234. The regfile reads 0x1234 from r5 after the following edge.
- Priority and order: push loads rd=7/0xAAAA then rd=8/0xBBBB while ALU rd=3 is valid for 3 cycles.
  - The regfile writes r3 ×3, then r7, then r8.
  - pending[7] and pending[8] are 1 until their writes.
- Full: hold alu_valid for 6 cycles and offer 5 loads.
  - mem_ready falls after the 4th transfer; the 5th is held.
  - When ALU traffic stops, the queue drains in order and the 5th load is accepted once q_count=3.
- Squash: queue rd=9/0x1111, then ALU rd=9/0x2222.
  - The regfile ends with r9=0x2222.
  - The squashed pop yields reg_write=0, and pending[9] clears the cycle after the squash.
  - Repeat with the ALU write in the same cycle as the push → same result.
- r0: an ALU write and a load both targeting rd=0 → reg_write is never asserted, q_count stays 0, and the mem transfer completes.
